// File: rtl/bnn_conv_seq.sv
// bnn_conv_seq: buffers one feature frame and issues every sliding KSIZE window
// to the conv engine, once per frame for NUM_FRAMES frames, then pulses done.
module bnn_conv_seq #(
  parameter int DW         = 16,
  parameter int KSIZE      = 5,
  parameter int FRAME_LEN  = 20,
  parameter int NUM_FRAMES = 6,
  localparam int NPOS = FRAME_LEN - KSIZE + 1,
  localparam int FW   = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1,
  localparam int PW   = NPOS > 1 ? $clog2(NPOS) : 1,
  localparam int WW   = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic                win_valid,
  output logic [KSIZE*DW-1:0] win_data,
  input  logic                win_ready,
  output logic [FW-1:0]       frame_idx,
  output logic [PW-1:0]       pos_idx,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t state, state_n;
  logic [FW-1:0] frame_n;
  logic [PW-1:0] pos_n;
  logic [WW-1:0] wr_idx, wr_n;
  logic [DW-1:0] mem [FRAME_LEN];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      frame_idx <= '0;
      pos_idx   <= '0;
      wr_idx    <= '0;
    end else begin
      state     <= state_n;
      frame_idx <= frame_n;
      pos_idx   <= pos_n;
      wr_idx    <= wr_n;
    end
  always_comb begin
    state_n = state;
    frame_n = frame_idx;
    pos_n   = pos_idx;
    wr_n    = wr_idx;
    if (abort) begin
      state_n = S_IDLE;
      frame_n = '0;
      pos_n   = '0;
      wr_n    = '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          state_n = S_LOAD;
          frame_n = '0;
          pos_n   = '0;
          wr_n    = '0;
        end
        S_LOAD: if (in_valid) begin
          wr_n = wr_idx == WW'(FRAME_LEN - 1) ? '0 : wr_idx + WW'(1);
          if (wr_idx == WW'(FRAME_LEN - 1)) begin
            state_n = S_RUN;
            pos_n   = '0;
          end
        end
        S_RUN: if (win_ready) begin
          pos_n = pos_idx == PW'(NPOS - 1) ? '0 : pos_idx + PW'(1);
          // last window of the frame: reload next frame or finish
          if (pos_idx == PW'(NPOS - 1)) begin
            state_n = frame_idx == FW'(NUM_FRAMES - 1) ? S_DONE : S_LOAD;
            frame_n = frame_idx == FW'(NUM_FRAMES - 1) ? frame_idx : frame_idx + FW'(1);
          end
        end
        S_DONE: state_n = S_IDLE;
      endcase
    end
  end
  assign in_ready  = state == S_LOAD;
  assign win_valid = state == S_RUN;
  assign busy      = state != S_IDLE;
  assign done      = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) mem[i] <= '0;
    end else if (in_ready && in_valid) begin
      mem[wr_idx] <= in_data;
    end
  // window is a pure slice of the buffer at the registered start position
  for (genvar k = 0; k < KSIZE; k++) begin : g_tap
    assign win_data[k*DW +: DW] = mem[WW'(pos_idx) + WW'(k)];
  end
endmodule

// File: tb/tb_bnn_conv_seq.sv
// tb_bnn_conv_seq: directed runs of the window sequencer with a sample-array
// reference model, plus table-checked windows and abort/reset corner cases.
module tb_bnn_conv_seq;
  localparam int DW = 16, KS = 5, FL = 20, NF = 6, NP = FL - KS + 1, NW = NP * NF, NS = FL * NF;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0, win_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, win_valid, busy, done;
  logic [KS*DW-1:0] win_data;
  logic [2:0] frame_idx;
  logic [3:0] pos_idx;
  int passed = 0, total = 0;
  logic [DW-1:0] samp [NS];
  logic [KS*DW-1:0] win_log [NW];

  typedef struct {
    int              w;
    logic [KS*DW-1:0] exp;
  } vec_t;
  vec_t tbl [5];

  bnn_conv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .frame_idx(frame_idx), .pos_idx(pos_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < NS; i++) samp[i] = DW'(base + i);
  endtask

  // stop_kind: 0 run to completion, 1 abort at window stop_w, 2 async reset at window stop_w
  task automatic run(input int gap, input bit rand_rdy, input bit junk, input int stop_w, input int stop_kind);
    int n_in, n_win, cyc, f, p;
    bit stalled;
    logic [KS*DW-1:0] held, exp;
    n_in = 0; n_win = 0; cyc = 0; stalled = 0; held = '0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (!done && cyc < 5000) begin
      if (stalled) check("stall_hold", {win_valid, win_data}, {1'b1, held});
      if (win_valid) check("in_ready_low_in_run", in_ready, 0);
      if (stop_kind != 0 && win_valid && n_win == stop_w) break;
      in_valid  = (cyc % gap) == 0;
      in_data   = n_in < NS ? samp[n_in] : '0;
      win_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = junk && win_valid && cyc[0];
      if (in_valid && in_ready) n_in++;
      stalled = win_valid && !win_ready;
      held    = win_data;
      if (win_valid && win_ready) begin
        f = n_win / NP; p = n_win % NP;
        for (int k = 0; k < KS; k++) exp[k*DW +: DW] = samp[f*FL + p + k];
        check("window", {frame_idx, pos_idx, win_data}, {3'(f), 4'(p), exp});
        if (n_win < NW) win_log[n_win] = win_data;
        n_win++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 0; win_ready = 0; start = 0;
    if (stop_kind == 0) begin
      check("done_seen", done, 1);
      check("win_count", n_win, NW);
      check("in_count", n_in, NS);
      check("final_idx", {frame_idx, pos_idx}, {3'd5, 4'd0});
      start = 1;
      @(negedge clk); start = 0;
      check("done_one_cycle_start_ignored", {done, busy, in_ready}, 0);
      check("final_idx_hold", {frame_idx, pos_idx}, {3'd5, 4'd0});
    end else if (stop_kind == 1) begin
      check("abort_point", {win_valid, frame_idx, pos_idx}, {1'b1, 3'd3, 4'd7});
      abort = 1; start = 1;
      @(negedge clk); abort = 0; start = 0;
      check("abort_idle", {busy, win_valid, in_ready, done, frame_idx, pos_idx}, 0);
      @(negedge clk);
      check("abort_start_dropped", {busy, done}, 0);
    end else begin
      check("reset_point", win_valid, 1);
      #1 rst_n = 0;
      #1 check("async_reset", {busy, win_valid, in_ready, done, frame_idx, pos_idx, win_data}, 0);
      #1 rst_n = 1;
      @(negedge clk);
      check("post_reset_idle", {busy, done}, 0);
    end
  endtask

  initial begin
    tbl[0] = '{0,  {16'd4,   16'd3,   16'd2,   16'd1,   16'd0}};
    tbl[1] = '{95, {16'd119, 16'd118, 16'd117, 16'd116, 16'd115}};
    tbl[2] = '{17, {16'd25,  16'd24,  16'd23,  16'd22,  16'd21}};
    tbl[3] = '{31, {16'd39,  16'd38,  16'd37,  16'd36,  16'd35}};
    tbl[4] = '{32, {16'd44,  16'd43,  16'd42,  16'd41,  16'd40}};
    repeat (2) @(negedge clk);
    check("reset_state", {busy, win_valid, in_ready, done, frame_idx, pos_idx, win_data}, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_after_reset", {busy, in_ready}, 0);
    fill(0);
    run(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) check($sformatf("table_w%0d", tbl[i].w), win_log[tbl[i].w], tbl[i].exp);
    fill(-60);
    run(1, 1, 0, 0, 0);
    fill(1000);
    run(3, 0, 0, 0, 0);
    fill(0);
    run(1, 0, 0, 3*NP + 7, 1);
    fill(-7);
    run(1, 0, 0, 0, 0);
    fill(200);
    run(1, 1, 1, 0, 0);
    fill(5);
    run(1, 0, 0, 20, 2);
    fill(-3000);
    run(2, 1, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
